serial_word_comp: RTL and testbench

- Bit-serial word comparator that consumes one bit pair per accepted cycle, MSB first.
- Accumulates WIDTH bit pairs and reports the word-level result: equal, greater or less.
- Also reports the count of differing bit positions (Hamming distance).
- Sits in the comparator datapath directly after the single-bit equality stage, turning per-bit comparisons into a registered word-level decision with a done handshake.

---
 rtl/serial_word_comp_if.sv | 28 ++
 rtl/serial_word_comp.sv | 144 ++++++++++++++
 tb/tb_serial_word_comp.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/serial_word_comp_if.sv
// Bit-pair stream and word-result bundle for the serial word comparator.
// The master drives the bit stream; the slave returns the registered word decision.
interface serial_word_comp_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic          start;
    logic          valid;
    logic          x;
    logic          y;
    logic          busy;
    logic          done;
    logic          eq;
    logic          gt;
    logic          lt;
    logic [CW-1:0] mism_cnt;

    modport master (
        output start, valid, x, y,
        input  busy, done, eq, gt, lt, mism_cnt
    );

    modport slave (
        input  start, valid, x, y,
        output busy, done, eq, gt, lt, mism_cnt
    );
endinterface

// File: rtl/serial_word_comp.sv
// Bit-serial MSB-first word comparator: folds WIDTH bit pairs into a registered
// eq/gt/lt decision plus Hamming distance, announced by a one-cycle done pulse.
module serial_word_comp #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_word_comp_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [BW-1:0] bit_cnt_r, bit_cnt_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          decided_r, decided_s;
    logic          gt_i_r, gt_i_s;
    logic          lt_i_r, lt_i_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          eq_r, eq_s;
    logic          gt_r, gt_s;
    logic          lt_r, lt_s;
    logic [CW-1:0] mism_r, mism_s;

    // Next-state, word-accumulation and result logic.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        cnt_s     = cnt_r;
        decided_s = decided_r;
        gt_i_s    = gt_i_r;
        lt_i_s    = lt_i_r;
        eq_s      = eq_r;
        gt_s      = gt_r;
        lt_s      = lt_r;
        mism_s    = mism_r;

        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_s   = SHIFT;
                    bit_cnt_s = '0;
                    cnt_s     = '0;
                    decided_s = 1'b0;
                    gt_i_s    = 1'b0;
                    lt_i_s    = 1'b0;
                    eq_s      = 1'b0;
                    gt_s      = 1'b0;
                    lt_s      = 1'b0;
                    mism_s    = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (bus.start) begin
                    bit_cnt_s = '0;
                    cnt_s     = '0;
                    decided_s = 1'b0;
                    gt_i_s    = 1'b0;
                    lt_i_s    = 1'b0;
                end else if (bus.valid) begin
                    bit_cnt_s = bit_cnt_r + BW'(1);
                    if (bus.x != bus.y) begin
                        cnt_s = cnt_r + CW'(1);
                        // Only the first (most significant) differing bit decides the order.
                        if (!decided_r) begin
                            decided_s = 1'b1;
                            gt_i_s    = bus.x & ~bus.y;
                            lt_i_s    = ~bus.x & bus.y;
                        end else begin
                            decided_s = decided_r;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                    if (bit_cnt_r == LAST_BIT) begin
                        state_s = DONE;
                        eq_s    = ~decided_s;
                        gt_s    = gt_i_s;
                        lt_s    = lt_i_s;
                        mism_s  = cnt_s;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s == SHIFT);
        done_s = (state_s == DONE);
    end

    // State, accumulator and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= '0;
            cnt_r     <= '0;
            decided_r <= 1'b0;
            gt_i_r    <= 1'b0;
            lt_i_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            eq_r      <= 1'b0;
            gt_r      <= 1'b0;
            lt_r      <= 1'b0;
            mism_r    <= '0;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            cnt_r     <= cnt_s;
            decided_r <= decided_s;
            gt_i_r    <= gt_i_s;
            lt_i_r    <= lt_i_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            eq_r      <= eq_s;
            gt_r      <= gt_s;
            lt_r      <= lt_s;
            mism_r    <= mism_s;
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.eq       = eq_r;
    assign bus.gt       = gt_r;
    assign bus.lt       = lt_r;
    assign bus.mism_cnt = mism_r;
endmodule

// File: tb/tb_serial_word_comp.sv
// Directed self-checking bench for serial_word_comp (WIDTH = 8) with
// hand-computed expected results for each word pair.
module tb_serial_word_comp;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   done_seen;

    serial_word_comp_if #(.WIDTH(8)) bus ();

    serial_word_comp #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) done_seen++;
    endtask

    task automatic check_res(input string tag, input logic e, input logic g, input logic l,
                             input logic [31:0] m);
        check_val({tag, "_eq"},   32'(bus.eq),       32'(e));
        check_val({tag, "_gt"},   32'(bus.gt),       32'(g));
        check_val({tag, "_lt"},   32'(bus.lt),       32'(l));
        check_val({tag, "_mism"}, 32'(bus.mism_cnt), m);
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        bus.valid = 1'b0;
        step();
        bus.start = 1'b0;
    endtask

    // Send 8 bits MSB first; optional one-cycle gap before each bit.
    task automatic send_bits(input string tag, input logic [7:0] xw, input logic [7:0] yw,
                             input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            if (gaps) begin
                bus.valid = 1'b0;
                bus.x     = ~xw[i];
                bus.y     = xw[i];
                step();
                check_val({tag, "_gap_busy"}, 32'(bus.busy), 32'd1);
                check_val({tag, "_gap_done"}, 32'(bus.done), 32'd0);
            end
            bus.valid = 1'b1;
            bus.x     = xw[i];
            bus.y     = yw[i];
            step();
            if (i > 0) begin
                check_val({tag, "_busy"}, 32'(bus.busy), 32'd1);
                check_val({tag, "_done"}, 32'(bus.done), 32'd0);
            end
        end
        bus.valid = 1'b0;
    endtask

    task automatic run_word(input string tag, input logic [7:0] xw, input logic [7:0] yw,
                            input bit gaps, input logic e, input logic g, input logic l,
                            input logic [31:0] m);
        int d0;
        d0 = done_seen;
        start_pulse();
        check_val({tag, "_start_busy"}, 32'(bus.busy), 32'd1);
        send_bits(tag, xw, yw, gaps);
        check_val({tag, "_done_pulse"}, 32'(bus.done), 32'd1);
        check_val({tag, "_done_busy"},  32'(bus.busy), 32'd0);
        check_val({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
        check_res(tag, e, g, l, m);
    endtask

    initial begin
        int d0;
        n_tests   = 0;
        n_fail    = 0;
        done_seen = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.valid = 1'b0;
        bus.x     = 1'b0;
        bus.y     = 1'b0;
        step();
        step();
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_res("rst", 1'b0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        step();

        // Reset mid-word
        start_pulse();
        bus.valid = 1'b1;
        bus.x     = 1'b1;
        bus.y     = 1'b0;
        step();
        step();
        step();
        bus.valid = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        check_val("midrst_busy", 32'(bus.busy), 32'd0);
        check_val("midrst_done", 32'(bus.done), 32'd0);
        check_res("midrst", 1'b0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        step();
        check_val("midrst_no_done", 32'(done_seen), 32'd0);

        // Equal words, then results held through IDLE
        run_word("equal", 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        check_val("equal_hold_done", 32'(bus.done), 32'd0);
        check_val("equal_hold_busy", 32'(bus.busy), 32'd0);
        step();
        check_res("equal_hold", 1'b1, 1'b0, 1'b0, 32'd0);

        run_word("msb", 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 32'd8);
        step();
        run_word("lsb", 8'h3C, 8'h3D, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
        step();
        run_word("gaps", 8'h0F, 8'h0E, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1);
        step();

        // Restart mid-word; the restart-cycle bit must be dropped
        d0 = done_seen;
        start_pulse();
        bus.valid = 1'b1;
        bus.x     = 1'b1;
        bus.y     = 1'b0;
        for (int i = 0; i < 4; i++) step();
        bus.start = 1'b1;
        step();
        check_val("restart_busy", 32'(bus.busy), 32'd1);
        check_val("restart_clr",  32'(bus.mism_cnt), 32'd0);
        bus.start = 1'b0;
        send_bits("restart", 8'h00, 8'hFF, 1'b0);
        check_val("restart_done",       32'(bus.done), 32'd1);
        check_val("restart_done_count", 32'(done_seen - d0), 32'd1);
        check_res("restart", 1'b0, 1'b0, 1'b1, 32'd8);
        step();

        // Start during DONE: next word begins with no idle cycle
        run_word("b2b_a", 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_val("b2b_busy", 32'(bus.busy), 32'd1);
        check_val("b2b_done", 32'(bus.done), 32'd0);
        check_res("b2b_clr", 1'b0, 1'b0, 1'b0, 32'd0);
        d0 = done_seen;
        send_bits("b2b_b", 8'h55, 8'h54, 1'b0);
        check_val("b2b_b_done",       32'(bus.done), 32'd1);
        check_val("b2b_b_done_count", 32'(done_seen - d0), 32'd1);
        check_res("b2b_b", 1'b0, 1'b1, 1'b0, 32'd1);
        step();
        check_val("final_done", 32'(bus.done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
